instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage of the multicycle CPU. Sits directly upstream of the byte-addressed instruction memory.
//  Owns the PC, drives the fetch address, and captures the returned 32-bit word into the IR.
//  Computes the next PC (PC+4, branch, jump or hold) under control-unit command.
//  Detects the HALT opcode and stops all further fetching.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC value loaded on reset
//  HALT_OPCODE  6'b111111      IR[31:26] value that enters the HALT state
// PORTS
//  CLK          in   1   single system clock, rising-edge
//  Reset        in   1   asynchronous, active-high reset
//  fetch_req    in   1   control unit requests an instruction fetch at the current PC
//  pc_write     in   1   commit a next-PC value selected by pc_src
//  pc_src       in   2   00 PC+4, 01 branch, 10 jump, 11 hold
//  branch_imm   in   16  signed word offset for a branch
//  jump_target  in   26  word-address field for a jump
//  imem_data    in   32  instruction word returned by the instruction memory (combinational read)
//  imem_addr    out  32  byte address to the instruction memory; always equals pc
//  ir           out  32  instruction register
//  ir_valid     out  1   one-cycle pulse: ir holds a newly fetched word
//  pc           out  32  current PC
//  pc_plus4     out  32  pc + 4, mod 2^32
//  busy         out  1   high in ADDR state
//  halted       out  1   high in HALT state; sticky until Reset
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, pc=RESET_PC, ir=0, ir_valid=0, busy=0, halted=0.
//   No ir_valid pulse after deassertion for a fetch that was in flight.
//  FSM (registered state):
//   IDLE: fetch_req=1 -> ADDR; otherwise stay in IDLE.
//   ADDR: busy=1; imem_addr=pc. At the rising edge: ir<=imem_data, then -> DONE.
//   DONE: ir_valid=1 for exactly this cycle.
//    If ir[31:26]==HALT_OPCODE -> HALT.
//    Else if fetch_req=1 -> ADDR (back-to-back fetch). Else -> IDLE.
//   HALT: halted=1; fetch_req and pc_write ignored; ir and pc frozen. Exit only via Reset.
//  Latency: fetch_req sampled high in IDLE at edge n.
//   -> ir updated at edge n+1; ir_valid high during the cycle after edge n+1.
//  PC update:
//   pc_write is honoured only in IDLE and DONE; ignored in ADDR and HALT.
//   The PC is therefore stable during the fetch.
//   PC+4   pc <= pc_plus4
//   branch pc <= pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00}
//   jump   pc <= {pc_plus4[31:28], jump_target, 2'b00}
//   hold   pc unchanged
//  Simultaneous pc_write and fetch_req in DONE: both take effect.
//   The new fetch uses the updated pc.
//  Arithmetic: all sums are 32-bit, modulo 2^32; no overflow flag.
//   0xFFFF_FFFC + 4 wraps to 0.
//  Alignment: pc[1:0] is forced to 00 on every write, whatever the source.
//  imem_addr is combinational from pc, not from the FSM.
// STRUCTURE
//  Shared header cpu_defines.vh:
//   PC_SRC_* encodings, HALT opcode, FSM state encodings (IDLE=0, ADDR=1, DONE=2, HALT=3).
//  One sub-module: pc_next_logic, purely combinational.
//   Inputs: pc, pc_src, branch_imm, jump_target. Outputs: next_pc, pc_plus4.
//  FSM, PC register and IR register live in the top module.
// TESTING
//  1. Reset; fetch_req=1 for 1 cycle; imem_data=32'hE000_0002
//     -> imem_addr=0, busy for 1 cycle, ir=32'hE000_0002, one ir_valid pulse, pc=0.
//  2. pc=0; pc_write=1, pc_src=00 in IDLE -> pc=4, pc_plus4=8.
//     Then pc=32'hFFFF_FFFC, same command -> pc=0.
//  3. pc=32'h34; branch_imm=16'hFFFE, pc_src=01 -> pc=32'h30.
//     pc_write during ADDR -> pc unchanged.
//  4. pc=32'h10; jump_target=26'h20, pc_src=10 -> pc=32'h80.
//  5. pc=32'h38, fetch; imem_data=32'hFC00_0000 -> ir_valid pulse, then halted=1.
//     Later fetch_req and pc_write -> no ir_valid, pc stays 32'h38.
//  6. Assert Reset in mid-ADDR -> state returns to IDLE immediately.
//     ir=0, pc=RESET_PC, ir_valid stays 0 for 3 cycles after release.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC source
// encodings, FSM state encoding, the default HALT opcode and a word
// alignment helper.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    PC_SRC_PLUS4  = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_HOLD   = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DONE = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'b111111;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_next_logic.sv
// pc_next_logic: purely combinational next-PC selection.
//   pc          in  32  current PC
//   pc_src      in   2  00 PC+4, 01 branch, 10 jump, 11 hold
//   branch_imm  in  16  signed word offset, relative to PC+4
//   jump_target in  26  word-address field, merged with PC+4[31:28]
//   next_pc     out 32  selected next PC, always word aligned
//   pc_plus4    out 32  pc + 4, modulo 2^32
module pc_next_logic
  import instruction_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_target,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] branch_off;

  always_comb begin
    pc_plus4   = pc + 32'd4;
    branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};
    next_pc    = pc;
    case (pc_src_e'(pc_src))
      PC_SRC_PLUS4:  next_pc = pc_plus4;
      PC_SRC_BRANCH: next_pc = pc_plus4 + branch_off;
      PC_SRC_JUMP:   next_pc = {pc_plus4[31:28], jump_target, 2'b00};
      PC_SRC_HOLD:   next_pc = pc;
      default:       next_pc = pc;
    endcase
    // Every write lands on a word boundary, whatever the source.
    next_pc = word_align(next_pc);
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch stage of the multicycle CPU.
// Owns the PC, addresses the instruction memory, captures the returned
// word into the IR and stops fetching for good on the HALT opcode.
//   CLK/Reset    clock, asynchronous active-high reset
//   fetch_req    request a fetch at the current PC
//   pc_write     commit next PC chosen by pc_src (IDLE and DONE only)
//   pc_src       00 PC+4, 01 branch, 10 jump, 11 hold
//   branch_imm   signed word offset for branches
//   jump_target  word-address field for jumps
//   imem_data    combinational instruction memory read data
//   imem_addr    byte address to instruction memory (== pc)
//   ir/ir_valid  instruction register, one-cycle new-word pulse
//   pc/pc_plus4  current PC and PC+4
//   busy/halted  in ADDR / in HALT (sticky)
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        fetch_req,
  input  logic        pc_write,
  input  logic [1:0]  pc_src,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_target,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        busy,
  output logic        halted
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  ir_q;
  logic         ir_valid_q;
  logic         busy_q;
  logic         halted_q;
  logic [31:0]  next_pc_d;

  pc_next_logic u_pc_next (
    .pc          (pc_q),
    .pc_src      (pc_src),
    .branch_imm  (branch_imm),
    .jump_target (jump_target),
    .next_pc     (next_pc_d),
    .pc_plus4    (pc_plus4)
  );

  // Status outputs are registered alongside the state so each one is
  // high exactly while the FSM sits in the matching state.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      ir_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pc_write) pc_q <= next_pc_d;
          if (fetch_req) begin
            state_q <= ST_ADDR;
            busy_q  <= 1'b1;
          end
        end
        ST_ADDR: begin
          ir_q       <= imem_data;
          ir_valid_q <= 1'b1;
          state_q    <= ST_DONE;
        end
        ST_DONE: begin
          // A PC commit here and a back-to-back fetch share the edge, so
          // the next ADDR cycle already presents the updated PC.
          if (pc_write) pc_q <= next_pc_d;
          if (ir_q[31:26] == HALT_OPCODE) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else if (fetch_req) begin
            state_q <= ST_ADDR;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_HALT: begin
          halted_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic        pc_write = 1'b0;
  logic [1:0]  pc_src = '0;
  logic [15:0] branch_imm = '0;
  logic [25:0] jump_target = '0;
  logic [31:0] imem_data;
  logic [31:0] imem_addr, ir, pc, pc_plus4;
  logic        ir_valid, busy, halted;

  instruction_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .HALT_OPCODE (6'b111111)
  ) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .fetch_req   (fetch_req),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .branch_imm  (branch_imm),
    .jump_target (jump_target),
    .imem_data   (imem_data),
    .imem_addr   (imem_addr),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .busy        (busy),
    .halted      (halted)
  );

  always #5 CLK = ~CLK;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } fetch_t;
  fetch_t exp_q[$];

  logic [31:0] model_pc;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_word = '0;
  logic [31:0] salt = '0;

  // Memory contents: a scrambled function of the address that never
  // carries the HALT opcode.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] w;
    w = (a * 32'h9E37_79B1) ^ salt;
    if (w[31:26] == 6'h3F) w[31] = 1'b0;
    return w;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return use_fixed ? fixed_word : word_at(a);
  endfunction

  assign imem_data = use_fixed ? fixed_word : word_at(imem_addr);

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [1:0] src,
                                           input logic [15:0] imm, input logic [25:0] jt);
    logic [31:0] p4, r;
    int          off;
    p4  = p + 32'd4;
    off = int'($signed(imm)) * 4;
    case (src)
      2'd0:    r = p4;
      2'd1:    r = p4 + 32'(off);
      2'd2:    r = {p4[31:28], jt, 2'b00};
      default: r = p;
    endcase
    r[1:0] = 2'b00;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_pc();
    chk("pc", pc, model_pc);
    chk("pc_plus4", pc_plus4, model_pc + 32'd4);
    chk("imem_addr", imem_addr, model_pc);
  endtask

  task automatic rand_cmd();
    pc_src      = 2'($urandom);
    branch_imm  = 16'($urandom);
    jump_target = 26'($urandom);
  endtask

  // PC command issued from IDLE.
  task automatic pcw(input logic [1:0] src, input logic [15:0] imm, input logic [25:0] jt);
    pc_src = src; branch_imm = imm; jump_target = jt; pc_write = 1'b1;
    tick();
    pc_write = 1'b0;
    model_pc = ref_next(model_pc, src, imm, jt);
    check_pc();
  endtask

  // One fetch from IDLE followed by 'extra' back-to-back fetches.
  task automatic fetch_seq(input int unsigned extra, input bit allow_pw);
    bit pw;
    rand_cmd();
    pw = allow_pw && ($urandom_range(0, 1) == 1);
    pc_write = pw; fetch_req = 1'b1;
    tick();
    if (pw) model_pc = ref_next(model_pc, pc_src, branch_imm, jump_target);
    exp_q.push_back('{model_pc, exp_word(model_pc)});
    for (int unsigned k = 0; k <= extra; k++) begin
      chk("busy in ADDR", busy, 1'b1);
      check_pc();
      rand_cmd();
      fetch_req = 1'($urandom); pc_write = 1'($urandom);
      tick();
      chk("busy in DONE", busy, 1'b0);
      check_pc();
      rand_cmd();
      pw = allow_pw && ($urandom_range(0, 1) == 1);
      pc_write = pw; fetch_req = (k < extra);
      tick();
      if (pw) model_pc = ref_next(model_pc, pc_src, branch_imm, jump_target);
      if (k < extra) exp_q.push_back('{model_pc, exp_word(model_pc)});
      fetch_req = 1'b0; pc_write = 1'b0;
      check_pc();
    end
  endtask

  // Scoreboard monitor: every ir_valid pulse consumes one expected fetch.
  always @(negedge CLK) begin
    if (!Reset && ir_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected ir_valid: ir=%h pc=%h expected no pulse", ir, pc);
      end else begin
        fetch_t e;
        e = exp_q.pop_front();
        chk("ir word", ir, e.word);
        chk("fetch pc", pc, e.addr);
      end
    end
  end

  initial begin
    salt = $urandom;
    #2;
    chk("reset pc", pc, 32'h0);
    chk("reset ir", ir, 32'h0);
    chk("reset ir_valid", ir_valid, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset halted", halted, 1'b0);
    tick();
    Reset = 1'b0;
    model_pc = 32'h0;

    // Fixed first fetch at address 0.
    use_fixed = 1'b1; fixed_word = 32'hE000_0002;
    fetch_seq(0, 1'b0);
    use_fixed = 1'b0;
    chk("t1 ir", ir, 32'hE000_0002);
    chk("t1 pc", pc, 32'h0);

    // Sequential increment and 32-bit wrap.
    pcw(2'b00, '0, '0);
    chk("t2 pc", pc, 32'h4);
    chk("t2 pc_plus4", pc_plus4, 32'h8);
    pcw(2'b01, 16'hFFFD, '0);
    chk("t2 pc top", pc, 32'hFFFF_FFFC);
    pcw(2'b00, '0, '0);
    chk("t2 wrap", pc, 32'h0);

    // Backward branch.
    pcw(2'b10, '0, 26'hD);
    chk("t3 pc", pc, 32'h34);
    pcw(2'b01, 16'hFFFE, '0);
    chk("t3 branch", pc, 32'h30);
    fetch_seq(0, 1'b0);

    // Jump.
    pcw(2'b10, '0, 26'h4);
    pcw(2'b10, '0, 26'h20);
    chk("t4 jump", pc, 32'h80);

    // Random traffic.
    for (int unsigned i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: begin rand_cmd(); pcw(pc_src, branch_imm, jump_target); end
        1, 2: fetch_seq($urandom_range(0, 3), 1'b1);
        default: begin tick(); check_pc(); end
      endcase
    end

    // HALT.
    pcw(2'b10, '0, 26'hE);
    chk("t5 pc", pc, 32'h38);
    use_fixed = 1'b1; fixed_word = 32'hFC00_0000;
    fetch_req = 1'b1;
    tick();
    exp_q.push_back('{model_pc, 32'hFC00_0000});
    fetch_req = 1'b0;
    tick();
    tick();
    chk("t5 halted", halted, 1'b1);
    for (int unsigned i = 0; i < 6; i++) begin
      rand_cmd();
      fetch_req = 1'($urandom); pc_write = 1'($urandom);
      tick();
      chk("halt pc frozen", pc, 32'h38);
      chk("halt ir frozen", ir, 32'hFC00_0000);
      chk("halt ir_valid", ir_valid, 1'b0);
      chk("halt busy", busy, 1'b0);
      chk("halt sticky", halted, 1'b1);
    end
    fetch_req = 1'b0; pc_write = 1'b0;
    use_fixed = 1'b0;

    Reset = 1'b1;
    #1;
    chk("halt reset", halted, 1'b0);
    tick();
    Reset = 1'b0;
    model_pc = 32'h0;

    // Reset in the middle of ADDR.
    pcw(2'b10, '0, 26'h123);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("t6 busy before", busy, 1'b1);
    #2;
    Reset = 1'b1;
    exp_q.delete();
    #1;
    chk("t6 busy", busy, 1'b0);
    chk("t6 pc", pc, 32'h0);
    chk("t6 ir", ir, 32'h0);
    chk("t6 ir_valid", ir_valid, 1'b0);
    tick();
    Reset = 1'b0;
    model_pc = 32'h0;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk("t6 no pulse", ir_valid, 1'b0);
      check_pc();
    end

    fetch_seq(2, 1'b1);
    tick();
    chk("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
